// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator context loader: source indices,
// stack-action encoding and the select-width helper.
package acc_pkg;

  localparam int SRC_MEM = 0;
  localparam int SRC_IMM = 1;
  localparam int SRC_ALU = 2;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_PUSH,
    ACT_POP,
    ACT_CONFLICT
  } stack_act_e;

  // Select width is never allowed to collapse to zero bits.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_ctx_loader_if.sv
// Source/control bundle into the accumulator loader and its status back out.
// Level-sampled controls: wr_en, push and pop act on every rising edge they
// are high, with no valid/ready handshake; all status outputs are registered.
interface acc_ctx_loader_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 3
);
  import acc_pkg::*;

  localparam int SELW = sel_width(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       sel;
  logic                  wr_en;
  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      acc;
  logic                  zero;
  logic                  neg;
  logic                  stk_empty;
  logic                  stk_full;
  logic                  stk_err;
  logic                  sel_err;

  modport master (
    output src_data, sel, wr_en, push, pop,
    input  acc, zero, neg, stk_empty, stk_full, stk_err, sel_err
  );

  modport slave (
    input  src_data, sel, wr_en, push, pop,
    output acc, zero, neg, stk_empty, stk_full, stk_err, sel_err
  );

endinterface

// File: rtl/acc_ctx_stack.sv
// LIFO context stack for the accumulator; flags illegal push/pop requests
// with a registered one-cycle error pulse.
module acc_ctx_stack #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;
  logic             bad_req;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PW'(STACK_DEPTH));
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign bad_req = (push && pop) || (push && full) || (pop && empty);
  assign top_idx = ptr - PW'(1);
  // Only meaningful while not empty; callers gate on that.
  assign dout    = mem[top_idx[IW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      err <= bad_req;
      if (do_push)
        ptr <= ptr + PW'(1);
      else if (do_pop)
        ptr <= ptr - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/acc_ctx_loader.sv
// Accumulator source mux with registered accumulator, zero/neg flags and a
// save/restore context stack for calls and interrupts.
module acc_ctx_loader
  import acc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NSRC        = 3,
  parameter int STACK_DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  acc_ctx_loader_if.slave  bus
);

  localparam int SELW = sel_width(NSRC);

  stack_act_e       act;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] stk_dout;
  logic [WIDTH-1:0] acc_q;
  logic             sel_bad;
  logic             wr_ok;
  logic             do_pop;
  logic             stk_empty;
  logic             stk_full;
  logic             stk_err;
  logic             sel_err_q;

  always_comb begin
    act = ACT_NONE;
    case ({bus.push, bus.pop})
      2'b10:   act = ACT_PUSH;
      2'b01:   act = ACT_POP;
      2'b11:   act = ACT_CONFLICT;
      default: act = ACT_NONE;
    endcase
  end

  // A pop or a push/pop conflict owns the accumulator for that edge.
  assign wr_ok   = bus.wr_en && (act == ACT_NONE || act == ACT_PUSH);
  assign do_pop  = (act == ACT_POP) && !stk_empty;
  assign sel_bad = (int'(bus.sel) >= NSRC);

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.sel == SELW'(i))
        sel_val = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= wr_ok && sel_bad;
      if (do_pop)
        acc_q <= stk_dout;
      else if (wr_ok && !sel_bad)
        acc_q <= sel_val;
    end
  end

  acc_ctx_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.push),
    .pop   (bus.pop),
    .din   (acc_q),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty),
    .err   (stk_err)
  );

  assign bus.acc       = acc_q;
  assign bus.zero      = (acc_q == '0);
  assign bus.neg       = acc_q[WIDTH-1];
  assign bus.stk_empty = stk_empty;
  assign bus.stk_full  = stk_full;
  assign bus.stk_err   = stk_err;
  assign bus.sel_err   = sel_err_q;

endmodule
